block_xfer_ctrl: RTL and testbench
==================================

# block_xfer_ctrl

Command sequencer that drives the register-bank/memory transfer datapath from the initiator side. It accepts one block-transfer request and expands it into a stream of per-word opcode/address/register commands. Supported directions are register bank to memory (store) and memory to register bank (load). It sits between the test/host logic and the register-bank/memory datapath, replacing hand-driven opcode sequences.

## Interface
- RD_WAIT, 2, extra cycles each load command is held so the synchronous memory read data settles before the last capture
- clka  input  1  clock; all state changes on rising edge
- rstn  input  1  asynchronous, active-low reset
- start  input  1  request strobe; sampled only in IDLE
- dir  input  1  0 = store (regs -> mem, opcode 01); 1 = load (mem -> regs, opcode 10)
- base_addr  input  4  first memory address
- first_reg  input  3  first register number
- count  input  4  number of words, legal 0..8
- opcode  output  2  command to datapath
- address  output  4  memory address of current command
- regNo  output  3  register number of current command
- cmd_valid  output  1  high while a store/load command is being presented
- busy  output  1  high from the cycle after accepted start through the DONE cycle
- done  output  1  one-cycle pulse, transfer complete
- err  output  1  one-cycle pulse, request rejected

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - opcode = 2'b11 (memory read to result only, never a write), cmd_valid = 0.
  - address and regNo hold their last values.
- Accepting a request: start = 1 in IDLE latches dir, base_addr, first_reg and count, and clears beat index i to 0.
  - count = 0: go to DONE; no command is issued.
  - count > 8: pulse err for one cycle, stay IDLE; no command is issued and busy stays 0.
  - Otherwise go to ISSUE.
- ISSUE:
  - opcode = dir ? 2'b10 : 2'b01; address = base_addr + i (mod 16); regNo = first_reg + i (mod 8); cmd_valid = 1.
  - Store: next beat is i+1 in ISSUE; after beat count-1, go to DONE.
  - Load: go to WAIT.
- WAIT (load only):
  - opcode, address and regNo are held unchanged; cmd_valid = 1.
  - Stays for RD_WAIT cycles, then goes to ISSUE with i+1, or to DONE after the last beat.
- DONE: done = 1 and busy = 1 for one cycle, opcode = 2'b11, cmd_valid = 0, then IDLE.
- start outside IDLE is ignored, with no queueing.
- Wrap-around is modular in both fields. Example: base_addr = 4'hE, count = 4 gives addresses E, F, 0, 1. first_reg = 6 gives registers 6, 7, 0, 1.
- Reset, including mid-transfer:
  - State returns to IDLE immediately and the partial transfer is abandoned.
  - Outputs: opcode = 2'b11, address = 0, regNo = 0, cmd_valid = 0, busy = 0, done = 0, err = 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- start is accepted at edge T. The first command is visible after edge T, and busy is 1 from that same cycle.
- Store, N words: N command cycles then 1 DONE cycle. busy is high N+1 cycles; done is in cycle N+1 after acceptance.
- Load, N words: N*(1+RD_WAIT) command cycles then 1 DONE cycle. busy is high N*(1+RD_WAIT)+1 cycles.
- count = 0: busy and done are both high in the single cycle after acceptance.
- err is in the cycle after acceptance; busy does not rise.
- A new start is accepted no earlier than the cycle after done (the first IDLE cycle).

## Test plan
- Reset: assert rstn = 0 mid-load, at i = 2 -> next cycle opcode = 11, cmd_valid = 0, busy = 0. After release, a new start is accepted normally.
- Store: base_addr = 3, first_reg = 0, count = 4, regs preloaded {1,2,3,4}:
  - opcode 01 for 4 cycles with address 3..6 and regNo 0..3; done at cycle 5.
  - Memory then reads 1,2,3,4 at addresses 3..6.
- Load round-trip, RD_WAIT = 2:
  - mem[8..A] = {A,B,C}, first_reg = 5, count = 3 -> each (address, regNo) pair held 3 cycles; busy for 10 cycles.
  - regs 5,6,7 = A,B,C.
- Wrap: store with base_addr = E, first_reg = 6, count = 4 -> addresses E, F, 0, 1 and regNo 6, 7, 0, 1.
- Boundary requests:
  - count = 0 -> done and busy for 1 cycle, no cmd_valid.
  - count = 9 -> err pulse, busy stays 0, opcode stays 11.
  - start pulsed while busy -> ignored; command stream unchanged.

Source files
------------

// File: rtl/block_xfer_ctrl.sv
// block_xfer_ctrl
// Turns one block-transfer request into a stream of per-word commands for
// the register-bank/memory datapath.
//   dir = 0 : store, register bank -> memory, opcode 01
//   dir = 1 : load,  memory -> register bank, opcode 10
// Each load command is held for 1 + RD_WAIT cycles so that the synchronous
// memory read data is settled before the final capture.
//
// Ports
//   clka       clock, rising edge
//   rstn       asynchronous active-low reset
//   start      request strobe, only looked at in IDLE
//   dir        transfer direction
//   base_addr  first memory address
//   first_reg  first register number
//   count      number of words (0..8 legal; above 8 is rejected)
//   opcode     command to the datapath (11 = read-only, never a write)
//   address    memory address of the current command
//   regNo      register number of the current command
//   cmd_valid  a store/load command is being presented
//   busy       transfer in progress, up to and including the DONE cycle
//   done       one-cycle completion pulse
//   err        one-cycle pulse, request rejected
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; opcode 11, address/regNo hold last values
// ISSUE | presenting beat i (store or load)
// WAIT  | load only: holding beat i for RD_WAIT extra cycles
// DONE  | one-cycle completion, done = busy = 1
//
// Every output is a decode of registered state or a register itself, so
// there is no combinational path from any input to any output.

module block_xfer_ctrl #(
   parameter int RD_WAIT = 2
) (
   input  logic       clka,
   input  logic       rstn,
   input  logic       start,
   input  logic       dir,
   input  logic [3:0] base_addr,
   input  logic [2:0] first_reg,
   input  logic [3:0] count,
   output logic [1:0] opcode,
   output logic [3:0] address,
   output logic [2:0] regNo,
   output logic       cmd_valid,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
   localparam logic [WW-1:0] WAIT_LOAD = WW'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
   localparam logic HAS_WAIT = (RD_WAIT > 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic            dir_q;
   logic [3:0]      beats_left;   // beats remaining after the current one
   logic [WW-1:0]   wait_cnt;     // down-counter for the load hold
   logic            req_bad;
   logic            req_go;
   logic            last_beat;
   logic            wait_tc;
   logic            load_hold;
   logic            advance;

   assign req_bad   = (count > 4'd8);
   assign req_go    = (state == S_IDLE) && start && !req_bad && (count != 4'd0);
   assign last_beat = (beats_left == 4'd0);
   assign wait_tc   = (wait_cnt == '0);
   assign load_hold = dir_q && HAS_WAIT;

   // Step to the next beat: a store beat that is not the last one, or the
   // end of a load hold that is not the last one.
   assign advance = ((state == S_ISSUE) && !load_hold && !last_beat) ||
                    ((state == S_WAIT) && wait_tc && !last_beat);

   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (count == 4'd0) begin
                  state_nx = S_DONE;
               end else if (!req_bad) begin
                  state_nx = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (load_hold) begin
               state_nx = S_WAIT;
            end else if (last_beat) begin
               state_nx = S_DONE;
            end
         end
         S_WAIT: begin
            if (wait_tc) begin
               state_nx = last_beat ? S_DONE : S_ISSUE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         dir_q      <= 1'b0;
         beats_left <= 4'd0;
         wait_cnt   <= '0;
         address    <= 4'd0;
         regNo      <= 3'd0;
         err        <= 1'b0;
      end else begin
         err <= (state == S_IDLE) && start && req_bad;
         if (req_go) begin
            dir_q      <= dir;
            beats_left <= count - 4'd1;
            address    <= base_addr;
            regNo      <= first_reg;
         end
         if (state == S_ISSUE) begin
            wait_cnt <= WAIT_LOAD;
         end else if ((state == S_WAIT) && !wait_tc) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         // Both fields wrap naturally at their own widths.
         if (advance) begin
            beats_left <= beats_left - 4'd1;
            address    <= address + 4'd1;
            regNo      <= regNo + 3'd1;
         end
      end
   end

   always_comb begin
      opcode    = 2'b11;
      cmd_valid = 1'b0;
      if ((state == S_ISSUE) || (state == S_WAIT)) begin
         opcode    = dir_q ? 2'b10 : 2'b01;
         cmd_valid = 1'b1;
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_block_xfer_ctrl.sv
module tb_block_xfer_ctrl;

   logic       clka;
   logic       rstn;
   logic       start;
   logic       dir;
   logic [3:0] base_addr;
   logic [2:0] first_reg;
   logic [3:0] count;
   logic [1:0] opcode;
   logic [3:0] address;
   logic [2:0] regNo;
   logic       cmd_valid;
   logic       busy;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   // Small register-bank / memory model that obeys the command stream.
   logic [7:0] mem_m  [16];
   logic [7:0] regs_m [8];
   logic       pl_en;
   logic       pl_mem;
   logic [3:0] pl_idx;
   logic [7:0] pl_val;

   block_xfer_ctrl #(.RD_WAIT(2)) dut (
      .clka      (clka),
      .rstn      (rstn),
      .start     (start),
      .dir       (dir),
      .base_addr (base_addr),
      .first_reg (first_reg),
      .count     (count),
      .opcode    (opcode),
      .address   (address),
      .regNo     (regNo),
      .cmd_valid (cmd_valid),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   always @(posedge clka) begin
      if (pl_en) begin
         if (pl_mem) mem_m[pl_idx] <= pl_val;
         else        regs_m[pl_idx[2:0]] <= pl_val;
      end else if (cmd_valid && opcode == 2'b01) begin
         mem_m[address] <= regs_m[regNo];
      end else if (cmd_valid && opcode == 2'b10) begin
         regs_m[regNo] <= mem_m[address];
      end
   end

   // {opcode, address, regNo, cmd_valid, busy, done, err}
   function automatic logic [13:0] pack(input logic [1:0] op, input logic [3:0] a,
                                        input logic [2:0] r, input logic cv,
                                        input logic bz, input logic dn, input logic er);
      return {op, a, r, cv, bz, dn, er};
   endfunction

   task automatic preload(input logic is_mem, input logic [3:0] idx, input logic [7:0] val);
      @(negedge clka);
      pl_en = 1'b1; pl_mem = is_mem; pl_idx = idx; pl_val = val;
      @(posedge clka);
      #1 pl_en = 1'b0;
   endtask

   // Returns just after the accepting edge; the next negedge is cycle 1.
   task automatic issue(input logic d, input logic [3:0] b, input logic [2:0] f,
                        input logic [3:0] n);
      @(negedge clka);
      start = 1'b1; dir = d; base_addr = b; first_reg = f; count = n;
      @(posedge clka);
      #1 start = 1'b0;
   endtask

   task automatic test_reset;
      logic [13:0] obs;
      rstn = 1'b0;
      repeat (3) @(negedge clka);
      obs = {opcode, address, regNo, cmd_valid, busy, done, err};
      checks++;
      if (obs !== pack(2'b11, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL reset_state got %h exp %h", obs, pack(2'b11, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      rstn = 1'b1;
      @(negedge clka);
   endtask

   task automatic test_store;
      logic [13:0] obs, exp;
      for (int k = 0; k < 4; k++) preload(1'b0, 4'(k), 8'(k + 1));
      issue(1'b0, 4'd3, 3'd0, 4'd4);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clka);
         if (c <= 4)      exp = pack(2'b01, 4'(3 + c - 1), 3'(c - 1), 1'b1, 1'b1, 1'b0, 1'b0);
         else if (c == 5) exp = pack(2'b11, 4'd6, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
         else             exp = pack(2'b11, 4'd6, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
         obs = {opcode, address, regNo, cmd_valid, busy, done, err};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL store_cycle%0d got %h exp %h", c, obs, exp);
         end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (mem_m[3 + k] !== 8'(k + 1)) begin
            errors++;
            $display("FAIL store_mem[%0d] got %h exp %h", 3 + k, mem_m[3 + k], 8'(k + 1));
         end
      end
   endtask

   task automatic test_load;
      logic [13:0] obs, exp;
      int busy_cycles;
      preload(1'b1, 4'h8, 8'h0A);
      preload(1'b1, 4'h9, 8'h0B);
      preload(1'b1, 4'hA, 8'h0C);
      for (int k = 5; k < 8; k++) preload(1'b0, 4'(k), 8'h00);
      busy_cycles = 0;
      issue(1'b1, 4'h8, 3'd5, 4'd3);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clka);
         if (c <= 9)       exp = pack(2'b10, 4'(8 + (c - 1) / 3), 3'(5 + (c - 1) / 3), 1'b1, 1'b1, 1'b0, 1'b0);
         else if (c == 10) exp = pack(2'b11, 4'hA, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0);
         else              exp = pack(2'b11, 4'hA, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
         if (busy === 1'b1) busy_cycles++;
         obs = {opcode, address, regNo, cmd_valid, busy, done, err};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL load_cycle%0d got %h exp %h", c, obs, exp);
         end
      end
      checks++;
      if (busy_cycles != 10) begin
         errors++;
         $display("FAIL load_busy_len got %0d exp 10", busy_cycles);
      end
      checks++;
      if ({regs_m[5], regs_m[6], regs_m[7]} !== 24'h0A0B0C) begin
         errors++;
         $display("FAIL load_regs got %h exp 0a0b0c", {regs_m[5], regs_m[6], regs_m[7]});
      end
   endtask

   task automatic test_wrap;
      logic [3:0] ea [4];
      logic [2:0] er [4];
      ea[0] = 4'hE; ea[1] = 4'hF; ea[2] = 4'h0; ea[3] = 4'h1;
      er[0] = 3'd6; er[1] = 3'd7; er[2] = 3'd0; er[3] = 3'd1;
      issue(1'b0, 4'hE, 3'd6, 4'd4);
      for (int c = 0; c < 4; c++) begin
         @(negedge clka);
         checks++;
         if ({opcode, cmd_valid, address, regNo} !== {2'b01, 1'b1, ea[c], er[c]}) begin
            errors++;
            $display("FAIL wrap_beat%0d got op=%b cv=%b a=%h r=%0d exp op=01 cv=1 a=%h r=%0d",
                     c, opcode, cmd_valid, address, regNo, ea[c], er[c]);
         end
      end
      @(negedge clka);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL wrap_done got %b exp 1", done);
      end
      @(negedge clka);
   endtask

   task automatic test_count_zero;
      issue(1'b0, 4'h2, 3'd1, 4'd0);
      @(negedge clka);
      checks++;
      if ({opcode, cmd_valid, busy, done, err} !== {2'b11, 1'b0, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL count0_c1 got op=%b cv=%b busy=%b done=%b err=%b exp op=11 cv=0 busy=1 done=1 err=0",
                  opcode, cmd_valid, busy, done, err);
      end
      @(negedge clka);
      checks++;
      if ({cmd_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL count0_c2 got cv/busy/done=%b exp 000", {cmd_valid, busy, done});
      end
   endtask

   task automatic test_count_nine;
      issue(1'b1, 4'h2, 3'd1, 4'd9);
      @(negedge clka);
      checks++;
      if ({opcode, cmd_valid, busy, done, err} !== {2'b11, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL count9_c1 got op=%b cv=%b busy=%b done=%b err=%b exp op=11 cv=0 busy=0 done=0 err=1",
                  opcode, cmd_valid, busy, done, err);
      end
      @(negedge clka);
      checks++;
      if ({opcode, busy, err} !== {2'b11, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL count9_c2 got op=%b busy=%b err=%b exp op=11 busy=0 err=0", opcode, busy, err);
      end
   endtask

   task automatic test_start_while_busy;
      logic [13:0] obs, exp;
      issue(1'b0, 4'h0, 3'd0, 4'd3);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clka);
         if (c <= 3)      exp = pack(2'b01, 4'(c - 1), 3'(c - 1), 1'b1, 1'b1, 1'b0, 1'b0);
         else if (c == 4) exp = pack(2'b11, 4'd2, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
         else             exp = pack(2'b11, 4'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
         obs = {opcode, address, regNo, cmd_valid, busy, done, err};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL busy_start_cycle%0d got %h exp %h", c, obs, exp);
         end
         if (c == 1) begin
            start = 1'b1; dir = 1'b1; base_addr = 4'h9; first_reg = 3'd4; count = 4'd5;
         end else if (c == 3) begin
            start = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid_load;
      logic [13:0] obs;
      issue(1'b1, 4'h8, 3'd5, 4'd3);
      repeat (7) @(negedge clka);
      checks++;
      if ({opcode, address, regNo} !== {2'b10, 4'hA, 3'd7}) begin
         errors++;
         $display("FAIL midload_beat2 got op=%b a=%h r=%0d exp op=10 a=a r=7", opcode, address, regNo);
      end
      rstn = 1'b0;
      #1;
      obs = {opcode, address, regNo, cmd_valid, busy, done, err};
      checks++;
      if (obs !== pack(2'b11, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL midload_reset got %h exp %h", obs, pack(2'b11, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      @(negedge clka);
      rstn = 1'b1;
      issue(1'b0, 4'h5, 3'd2, 4'd1);
      @(negedge clka);
      obs = {opcode, address, regNo, cmd_valid, busy, done, err};
      checks++;
      if (obs !== pack(2'b01, 4'h5, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL post_reset_c1 got %h exp %h", obs, pack(2'b01, 4'h5, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0));
      end
      @(negedge clka);
      checks++;
      if ({busy, done} !== 2'b11) begin
         errors++;
         $display("FAIL post_reset_done got busy/done=%b exp 11", {busy, done});
      end
      @(negedge clka);
   endtask

   initial begin
      start = 1'b0; dir = 1'b0; base_addr = 4'd0; first_reg = 3'd0; count = 4'd0;
      pl_en = 1'b0; pl_mem = 1'b0; pl_idx = 4'd0; pl_val = 8'd0;
      test_reset;
      test_store;
      test_load;
      test_wrap;
      test_count_zero;
      test_count_nine;
      test_start_while_busy;
      test_reset_mid_load;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
